// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat pulses.
// Each event is registered, so it appears in the cycle after the clock edge that detects it.
module btn_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned DBL_CYCLES    = 25_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_deb,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HELD     = 3'd1,
        S_REPEAT   = 3'd2,
        S_GAP      = 3'd3,
        S_DBL_HELD = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_q;

    logic w_rise;
    logic w_fall;

    assign w_rise = btn_deb & ~r_btn_q;
    assign w_fall = ~btn_deb & r_btn_q;

    // Edges are tested before counter expiry so a simultaneous edge always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_btn_q       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_pulse  <= 1'b0;
            double_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            r_btn_q       <= btn_deb;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_pulse  <= 1'b0;
            double_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            r_cnt         <= r_cnt + CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        r_state     <= S_HELD;
                        r_cnt       <= '0;
                    end
                end

                S_HELD: begin
                    if (w_fall) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        r_state       <= S_GAP;
                        r_cnt         <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        r_state    <= S_REPEAT;
                        r_cnt      <= '0;
                    end
                end

                S_REPEAT: begin
                    if (w_fall) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        r_state       <= S_IDLE;
                        r_cnt         <= '0;
                    end else if (r_cnt == REPEAT_LAST) begin
                        repeat_pulse <= 1'b1;
                        r_cnt        <= '0;
                    end
                end

                S_GAP: begin
                    if (w_rise) begin
                        press_pulse  <= 1'b1;
                        double_pulse <= 1'b1;
                        held         <= 1'b1;
                        r_state      <= S_DBL_HELD;
                        r_cnt        <= '0;
                    end else if (r_cnt == DBL_LAST) begin
                        single_pulse <= 1'b1;
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                    end
                end

                S_DBL_HELD: begin
                    if (w_fall) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        r_state       <= S_IDLE;
                        r_cnt         <= '0;
                    end
                end

                default: begin
                    held    <= 1'b0;
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
